// File: rtl/alu_rs.sv
// alu_rs: reservation station in front of the integer ALU.
// Holds dispatched ALU / branch-compare micro-ops, captures operands from the
// ALU and load/store CDB broadcasts, and issues at most one ready entry per
// cycle as {rob_id, op, v1, v2} on registered outputs.
module alu_rs #(
    parameter int RS_SIZE        = 8,
    parameter int ROB_SIZE_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      flush,

    input  logic                      dispatch_valid,
    input  logic [4:0]                dispatch_op,
    input  logic [ROB_SIZE_WIDTH-1:0] dispatch_rob_id,
    input  logic [31:0]               dispatch_vj,
    input  logic [31:0]               dispatch_vk,
    input  logic                      dispatch_qj_busy,
    input  logic                      dispatch_qk_busy,
    input  logic [ROB_SIZE_WIDTH-1:0] dispatch_qj,
    input  logic [ROB_SIZE_WIDTH-1:0] dispatch_qk,
    output logic                      full,

    input  logic                      alu_cdb_valid,
    input  logic [ROB_SIZE_WIDTH-1:0] alu_cdb_rob_id,
    input  logic [31:0]               alu_cdb_value,
    input  logic                      lsb_cdb_valid,
    input  logic [ROB_SIZE_WIDTH-1:0] lsb_cdb_rob_id,
    input  logic [31:0]               lsb_cdb_value,

    output logic                      issue_valid,
    output logic [ROB_SIZE_WIDTH-1:0] issue_rob_id,
    output logic [4:0]                issue_op,
    output logic [31:0]               issue_v1,
    output logic [31:0]               issue_v2
);

    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    // Entry storage
    logic [RS_SIZE-1:0]        busy;
    logic [RS_SIZE-1:0]        qj_busy;
    logic [RS_SIZE-1:0]        qk_busy;
    logic [4:0]                op_q    [RS_SIZE];
    logic [ROB_SIZE_WIDTH-1:0] rob_q   [RS_SIZE];
    logic [31:0]               vj_q    [RS_SIZE];
    logic [31:0]               vk_q    [RS_SIZE];
    logic [ROB_SIZE_WIDTH-1:0] qj_q    [RS_SIZE];
    logic [ROB_SIZE_WIDTH-1:0] qk_q    [RS_SIZE];

    // Select / allocate results
    logic                      sel_found;
    logic [IDX_W-1:0]          sel_idx;
    logic                      free_found;
    logic [IDX_W-1:0]          free_idx;

    // Dispatch operands after CDB bypass
    logic                      disp_qj_busy_eff;
    logic                      disp_qk_busy_eff;
    logic [31:0]               disp_vj_eff;
    logic [31:0]               disp_vk_eff;

    // Per-entry wakeup hits on each bus
    logic [RS_SIZE-1:0]        wake_j_alu;
    logic [RS_SIZE-1:0]        wake_j_lsb;
    logic [RS_SIZE-1:0]        wake_k_alu;
    logic [RS_SIZE-1:0]        wake_k_lsb;

    logic                      do_dispatch;

    // full ignores a concurrent issue, so a freed slot is reusable next cycle
    assign full        = &busy;
    assign do_dispatch = dispatch_valid && !full && free_found;

    // Pick the lowest-index busy entry whose operands are both captured
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (busy[i] && !qj_busy[i] && !qk_busy[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // Pick the lowest-index free entry for dispatch
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Dispatch bypass: a tag broadcast in the dispatch cycle is captured directly;
    // the ALU bus wins if both buses carry the same tag
    always_comb begin
        disp_qj_busy_eff = dispatch_qj_busy;
        disp_vj_eff      = dispatch_vj;
        if (dispatch_qj_busy) begin
            if (alu_cdb_valid && alu_cdb_rob_id == dispatch_qj) begin
                disp_qj_busy_eff = 1'b0;
                disp_vj_eff      = alu_cdb_value;
            end else if (lsb_cdb_valid && lsb_cdb_rob_id == dispatch_qj) begin
                disp_qj_busy_eff = 1'b0;
                disp_vj_eff      = lsb_cdb_value;
            end
        end

        disp_qk_busy_eff = dispatch_qk_busy;
        disp_vk_eff      = dispatch_vk;
        if (dispatch_qk_busy) begin
            if (alu_cdb_valid && alu_cdb_rob_id == dispatch_qk) begin
                disp_qk_busy_eff = 1'b0;
                disp_vk_eff      = alu_cdb_value;
            end else if (lsb_cdb_valid && lsb_cdb_rob_id == dispatch_qk) begin
                disp_qk_busy_eff = 1'b0;
                disp_vk_eff      = lsb_cdb_value;
            end
        end
    end

    // Tag match of every waiting operand against both broadcasts
    always_comb begin
        wake_j_alu = '0;
        wake_j_lsb = '0;
        wake_k_alu = '0;
        wake_k_lsb = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            wake_j_alu[i] = busy[i] && qj_busy[i] && alu_cdb_valid && (qj_q[i] == alu_cdb_rob_id);
            wake_j_lsb[i] = busy[i] && qj_busy[i] && lsb_cdb_valid && (qj_q[i] == lsb_cdb_rob_id);
            wake_k_alu[i] = busy[i] && qk_busy[i] && alu_cdb_valid && (qk_q[i] == alu_cdb_rob_id);
            wake_k_lsb[i] = busy[i] && qk_busy[i] && lsb_cdb_valid && (qk_q[i] == lsb_cdb_rob_id);
        end
    end

    // Entry array update: wakeup, issue clear, dispatch write, flush
    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= '0;
            qj_busy <= '0;
            qk_busy <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                op_q[i]  <= '0;
                rob_q[i] <= '0;
                vj_q[i]  <= '0;
                vk_q[i]  <= '0;
                qj_q[i]  <= '0;
                qk_q[i]  <= '0;
            end
        end else if (rdy) begin
            if (flush) begin
                busy <= '0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (wake_j_alu[i]) begin
                        vj_q[i]    <= alu_cdb_value;
                        qj_busy[i] <= 1'b0;
                    end else if (wake_j_lsb[i]) begin
                        vj_q[i]    <= lsb_cdb_value;
                        qj_busy[i] <= 1'b0;
                    end
                    if (wake_k_alu[i]) begin
                        vk_q[i]    <= alu_cdb_value;
                        qk_busy[i] <= 1'b0;
                    end else if (wake_k_lsb[i]) begin
                        vk_q[i]    <= lsb_cdb_value;
                        qk_busy[i] <= 1'b0;
                    end
                end

                if (sel_found) begin
                    busy[sel_idx] <= 1'b0;
                end

                // The free slot is never the issuing one, since that one is busy
                if (do_dispatch) begin
                    busy[free_idx]    <= 1'b1;
                    op_q[free_idx]    <= dispatch_op;
                    rob_q[free_idx]   <= dispatch_rob_id;
                    vj_q[free_idx]    <= disp_vj_eff;
                    vk_q[free_idx]    <= disp_vk_eff;
                    qj_busy[free_idx] <= disp_qj_busy_eff;
                    qk_busy[free_idx] <= disp_qk_busy_eff;
                    qj_q[free_idx]    <= dispatch_qj;
                    qk_q[free_idx]    <= dispatch_qk;
                end
            end
        end
    end

    // Issue register: pulse for one cycle per selected entry, payload held otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_valid  <= 1'b0;
            issue_rob_id <= '0;
            issue_op     <= '0;
            issue_v1     <= '0;
            issue_v2     <= '0;
        end else if (rdy) begin
            if (flush) begin
                issue_valid <= 1'b0;
            end else if (sel_found) begin
                issue_valid  <= 1'b1;
                issue_rob_id <= rob_q[sel_idx];
                issue_op     <= op_q[sel_idx];
                issue_v1     <= vj_q[sel_idx];
                issue_v2     <= vk_q[sel_idx];
            end else begin
                issue_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Testbench for alu_rs: directed scenarios plus a randomized run checked
// against an entry-list reference model.
module tb_alu_rs;

    localparam int RS = 8;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst, rdy, flush;
    logic          dispatch_valid;
    logic [4:0]    dispatch_op;
    logic [RW-1:0] dispatch_rob_id;
    logic [31:0]   dispatch_vj, dispatch_vk;
    logic          dispatch_qj_busy, dispatch_qk_busy;
    logic [RW-1:0] dispatch_qj, dispatch_qk;
    logic          full;
    logic          alu_cdb_valid;
    logic [RW-1:0] alu_cdb_rob_id;
    logic [31:0]   alu_cdb_value;
    logic          lsb_cdb_valid;
    logic [RW-1:0] lsb_cdb_rob_id;
    logic [31:0]   lsb_cdb_value;
    logic          issue_valid;
    logic [RW-1:0] issue_rob_id;
    logic [4:0]    issue_op;
    logic [31:0]   issue_v1, issue_v2;

    int tests_run = 0;
    int tests_failed = 0;

    alu_rs #(.RS_SIZE(RS), .ROB_SIZE_WIDTH(RW)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_op(dispatch_op),
        .dispatch_rob_id(dispatch_rob_id), .dispatch_vj(dispatch_vj),
        .dispatch_vk(dispatch_vk), .dispatch_qj_busy(dispatch_qj_busy),
        .dispatch_qk_busy(dispatch_qk_busy), .dispatch_qj(dispatch_qj),
        .dispatch_qk(dispatch_qk), .full(full),
        .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob_id(alu_cdb_rob_id),
        .alu_cdb_value(alu_cdb_value), .lsb_cdb_valid(lsb_cdb_valid),
        .lsb_cdb_rob_id(lsb_cdb_rob_id), .lsb_cdb_value(lsb_cdb_value),
        .issue_valid(issue_valid), .issue_rob_id(issue_rob_id),
        .issue_op(issue_op), .issue_v1(issue_v1), .issue_v2(issue_v2)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        bit          busy;
        logic [4:0]  op;
        logic [3:0]  rob;
        logic [31:0] vj, vk;
        bit          qjb, qkb;
        logic [3:0]  qj, qk;
    } ent_t;

    ent_t        m[RS];
    bit          m_iv;
    logic [3:0]  m_irob;
    logic [4:0]  m_iop;
    logic [31:0] m_iv1, m_iv2;

    // Operand capture from the buses this cycle (ALU bus preferred)
    function automatic void resolve(input bit qb, input logic [3:0] q, input logic [31:0] v,
                                    output bit qb_o, output logic [31:0] v_o);
        qb_o = qb;
        v_o  = v;
        if (qb && alu_cdb_valid && alu_cdb_rob_id == q) begin
            qb_o = 0; v_o = alu_cdb_value;
        end else if (qb && lsb_cdb_valid && lsb_cdb_rob_id == q) begin
            qb_o = 0; v_o = lsb_cdb_value;
        end
    endfunction

    function automatic bit model_full();
        int n = 0;
        for (int i = 0; i < RS; i++) if (m[i].busy) n++;
        return n == RS;
    endfunction

    // Advance the model by one clock edge using the current input values
    function automatic void model_step();
        ent_t old[RS];
        int   sel = -1;
        int   fr = -1;
        bit   was_full;
        if (rst) begin
            for (int i = 0; i < RS; i++) m[i].busy = 0;
            m_iv = 0; m_irob = 0; m_iop = 0; m_iv1 = 0; m_iv2 = 0;
            return;
        end
        if (!rdy) return;
        if (flush) begin
            for (int i = 0; i < RS; i++) m[i].busy = 0;
            m_iv = 0;
            return;
        end
        old = m;
        was_full = model_full();
        for (int i = 0; i < RS; i++) begin
            if (sel < 0 && old[i].busy && !old[i].qjb && !old[i].qkb) sel = i;
            if (fr < 0 && !old[i].busy) fr = i;
        end
        for (int i = 0; i < RS; i++) begin
            if (old[i].busy) begin
                resolve(old[i].qjb, old[i].qj, old[i].vj, m[i].qjb, m[i].vj);
                resolve(old[i].qkb, old[i].qk, old[i].vk, m[i].qkb, m[i].vk);
            end
        end
        if (sel >= 0) begin
            m[sel].busy = 0;
            m_iv = 1; m_irob = old[sel].rob; m_iop = old[sel].op;
            m_iv1 = old[sel].vj; m_iv2 = old[sel].vk;
        end else begin
            m_iv = 0;
        end
        if (dispatch_valid && !was_full) begin
            m[fr].busy = 1;
            m[fr].op   = dispatch_op;
            m[fr].rob  = dispatch_rob_id;
            m[fr].qj   = dispatch_qj;
            m[fr].qk   = dispatch_qk;
            resolve(dispatch_qj_busy, dispatch_qj, dispatch_vj, m[fr].qjb, m[fr].vj);
            resolve(dispatch_qk_busy, dispatch_qk, dispatch_vk, m[fr].qkb, m[fr].vk);
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rdy = 1; flush = 0;
        dispatch_valid = 0; dispatch_op = 0; dispatch_rob_id = 0;
        dispatch_vj = 0; dispatch_vk = 0;
        dispatch_qj_busy = 0; dispatch_qk_busy = 0; dispatch_qj = 0; dispatch_qk = 0;
        alu_cdb_valid = 0; alu_cdb_rob_id = 0; alu_cdb_value = 0;
        lsb_cdb_valid = 0; lsb_cdb_rob_id = 0; lsb_cdb_value = 0;
    endtask

    task automatic set_dispatch(input logic [4:0] op, input logic [3:0] rob,
                                input logic [31:0] vj, input logic [31:0] vk,
                                input bit qjb, input logic [3:0] qj,
                                input bit qkb, input logic [3:0] qk);
        dispatch_valid = 1; dispatch_op = op; dispatch_rob_id = rob;
        dispatch_vj = vj; dispatch_vk = vk;
        dispatch_qj_busy = qjb; dispatch_qj = qj;
        dispatch_qk_busy = qkb; dispatch_qk = qk;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1;
        idle_inputs();
        tick();
        tick();
        tests_run++;
        if ({issue_valid, full, issue_rob_id, issue_op, issue_v1, issue_v2} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: got iv=%b full=%b rob=%0d op=%0d v1=%h v2=%h, want all zero",
                     issue_valid, full, issue_rob_id, issue_op, issue_v1, issue_v2);
        end
        rst = 0;
    endtask

    task automatic test_ready_dispatch();
        set_dispatch(5'b00000, 4'd3, 32'd7, 32'd5, 0, 0, 0, 0);
        tick();
        idle_inputs();
        tests_run++;
        if (issue_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL ready_dispatch_latency: issue_valid=%b after dispatch edge, want 0", issue_valid);
        end
        tick();
        tests_run++;
        if ({issue_valid, issue_rob_id, issue_op, issue_v1, issue_v2} !== {1'b1, 4'd3, 5'd0, 32'd7, 32'd5}) begin
            tests_failed++;
            $display("FAIL ready_dispatch_issue: got iv=%b rob=%0d op=%0d v1=%0d v2=%0d, want 1/3/0/7/5",
                     issue_valid, issue_rob_id, issue_op, issue_v1, issue_v2);
        end
        tick();
        tests_run++;
        if (issue_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL ready_dispatch_single_pulse: issue_valid=%b, want 0", issue_valid);
        end
    endtask

    task automatic test_cdb_wakeup();
        set_dispatch(5'b00001, 4'd2, 32'hDEAD, 32'd1, 1, 4'd6, 0, 0);
        tick();
        idle_inputs();
        tick();
        tests_run++;
        if (issue_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL wakeup_wait: issue_valid=%b while operand pending, want 0", issue_valid);
        end
        alu_cdb_valid = 1; alu_cdb_rob_id = 4'd6; alu_cdb_value = 32'h10;
        tick();
        idle_inputs();
        tests_run++;
        if (issue_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL wakeup_latency: issue_valid=%b on wake edge, want 0", issue_valid);
        end
        tick();
        tests_run++;
        if ({issue_valid, issue_rob_id, issue_op, issue_v1, issue_v2} !== {1'b1, 4'd2, 5'd1, 32'h10, 32'd1}) begin
            tests_failed++;
            $display("FAIL wakeup_issue: got iv=%b rob=%0d op=%0d v1=%h v2=%h, want 1/2/1/10/1",
                     issue_valid, issue_rob_id, issue_op, issue_v1, issue_v2);
        end
        tick();
    endtask

    task automatic test_dispatch_bypass();
        set_dispatch(5'b10010, 4'd4, 32'd9, 32'h0, 0, 0, 1, 4'd9);
        lsb_cdb_valid = 1; lsb_cdb_rob_id = 4'd9; lsb_cdb_value = 32'hABCD;
        tick();
        idle_inputs();
        tick();
        tests_run++;
        if ({issue_valid, issue_rob_id, issue_op, issue_v1, issue_v2} !== {1'b1, 4'd4, 5'b10010, 32'd9, 32'hABCD}) begin
            tests_failed++;
            $display("FAIL bypass_issue: got iv=%b rob=%0d op=%b v1=%h v2=%h, want 1/4/10010/9/abcd",
                     issue_valid, issue_rob_id, issue_op, issue_v1, issue_v2);
        end
        tick();
    endtask

    task automatic test_full();
        for (int i = 0; i < RS; i++) begin
            set_dispatch(5'd3, 4'(i), 32'd0, 32'(i + 100), 1, 4'd1, 0, 0);
            tick();
        end
        tests_run++;
        if (full !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_assert: full=%b after %0d dispatches, want 1", full, RS);
        end
        set_dispatch(5'd3, 4'd9, 32'd0, 32'd999, 0, 0, 0, 0);
        tick();
        idle_inputs();
        alu_cdb_valid = 1; alu_cdb_rob_id = 4'd1; alu_cdb_value = 32'h55;
        tick();
        idle_inputs();
        tests_run++;
        if ({issue_valid, full} !== 2'b01) begin
            tests_failed++;
            $display("FAIL full_wake_edge: got iv=%b full=%b, want iv=0 full=1", issue_valid, full);
        end
        for (int i = 0; i < RS; i++) begin
            tick();
            tests_run++;
            if ({issue_valid, issue_rob_id, issue_v1, issue_v2} !== {1'b1, 4'(i), 32'h55, 32'(i + 100)}) begin
                tests_failed++;
                $display("FAIL full_drain_%0d: got iv=%b rob=%0d v1=%h v2=%0d, want 1/%0d/55/%0d",
                         i, issue_valid, issue_rob_id, issue_v1, issue_v2, i, i + 100);
            end
            if (i == 0) begin
                tests_run++;
                if (full !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL full_release: full=%b after first issue, want 0", full);
                end
            end
        end
        tick();
        tests_run++;
        if (issue_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_drop: issue_valid=%b rob=%0d, dropped dispatch must not issue",
                     issue_valid, issue_rob_id);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            set_dispatch(5'd4, 4'(10 + i), 32'd0, 32'd0, 1, 4'd5, 0, 0);
            tick();
        end
        set_dispatch(5'd2, 4'd7, 32'd1, 32'd2, 0, 0, 0, 0);
        flush = 1;
        tick();
        idle_inputs();
        tests_run++;
        if ({full, issue_valid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL flush_clear: got full=%b iv=%b, want 0/0", full, issue_valid);
        end
        alu_cdb_valid = 1; alu_cdb_rob_id = 4'd5; alu_cdb_value = 32'h77;
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (issue_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL flush_no_issue_%0d: issue_valid=%b rob=%0d, want 0", i, issue_valid, issue_rob_id);
            end
        end
    endtask

    task automatic test_rdy_hold();
        set_dispatch(5'd6, 4'd6, 32'h11, 32'h22, 0, 0, 0, 0);
        tick();
        idle_inputs();
        tick();
        rdy = 0;
        set_dispatch(5'd7, 4'd8, 32'h33, 32'h44, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if ({issue_valid, issue_rob_id, issue_op, issue_v1, issue_v2} !== {1'b1, 4'd6, 5'd6, 32'h11, 32'h22}) begin
                tests_failed++;
                $display("FAIL rdy_hold_%0d: got iv=%b rob=%0d op=%0d v1=%h v2=%h, want 1/6/6/11/22",
                         i, issue_valid, issue_rob_id, issue_op, issue_v1, issue_v2);
            end
        end
        idle_inputs();
        tick();
        tests_run++;
        if ({issue_valid, issue_rob_id} !== {1'b0, 4'd6}) begin
            tests_failed++;
            $display("FAIL rdy_resume: got iv=%b rob=%0d, want iv=0 rob held 6", issue_valid, issue_rob_id);
        end
    endtask

    task automatic test_random();
        int errs = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rdy   = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 99) == 0);
            dispatch_valid   = ($urandom_range(0, 2) != 0);
            dispatch_op      = 5'($urandom);
            dispatch_rob_id  = 4'($urandom);
            dispatch_vj      = $urandom;
            dispatch_vk      = $urandom;
            dispatch_qj_busy = $urandom_range(0, 1) == 1;
            dispatch_qk_busy = $urandom_range(0, 1) == 1;
            dispatch_qj      = 4'($urandom_range(0, 3));
            dispatch_qk      = 4'($urandom_range(0, 3));
            alu_cdb_valid    = $urandom_range(0, 2) == 0;
            alu_cdb_rob_id   = 4'($urandom_range(0, 3));
            alu_cdb_value    = $urandom;
            lsb_cdb_valid    = $urandom_range(0, 2) == 0;
            lsb_cdb_rob_id   = 4'($urandom_range(0, 3));
            lsb_cdb_value    = $urandom;
            tick();
            tests_run++;
            if ({issue_valid, full} !== {m_iv, model_full()} ||
                (m_iv && {issue_rob_id, issue_op, issue_v1, issue_v2} !== {m_irob, m_iop, m_iv1, m_iv2})) begin
                tests_failed++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_cycle_%0d: got iv=%b full=%b rob=%0d op=%0d v1=%h v2=%h, want iv=%b full=%b rob=%0d op=%0d v1=%h v2=%h",
                             c, issue_valid, full, issue_rob_id, issue_op, issue_v1, issue_v2,
                             m_iv, model_full(), m_irob, m_iop, m_iv1, m_iv2);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_ready_dispatch();
        test_cdb_wakeup();
        test_dispatch_bypass();
        test_full();
        test_flush();
        test_rdy_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
